// File: rtl/store_buffer.sv
// Posted-write store queue between EX/MEM and data memory, with load overlap check.
// Optional lw-from-sw forwarding is enabled by defining STORE_BUFFER_FWD_EN.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [31:0] in_pc,
  input  logic        ld_valid,
  input  logic [5:0]  ld_opcode,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic [31:0] ld_data,
  output logic        ld_stall,
  output logic        mem_WR,
  output logic [5:0]  mem_opcode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_pc,
  output logic        empty,
  output logic        align_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_LW = 6'b100011;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  entry_t           q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic full;
  logic is_store;
  logic aligned;
  logic push;
  logic pop;
  logic misalign;

  // Youngest matching entry for the load check
  logic [PTR_W-1:0] idx;
  logic             match;
  logic [5:0]       y_op;
  logic [31:0]      y_data;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign mem_WR   = !empty && !ld_valid;
  assign pop      = mem_WR;

  // Store decode and alignment
  always_comb begin
    is_store = 1'b0;
    aligned  = 1'b0;
    case (in_opcode)
      OP_SW: begin is_store = 1'b1; aligned = (in_addr[1:0] == 2'b00); end
      OP_SH: begin is_store = 1'b1; aligned = !in_addr[0]; end
      OP_SB: begin is_store = 1'b1; aligned = 1'b1; end
      default: begin is_store = 1'b0; aligned = 1'b0; end
    endcase
  end

  assign push     = in_valid && in_ready && is_store && aligned;
  assign misalign = in_valid && in_ready && is_store && !aligned;

  assign mem_opcode     = q[head].opcode;
  assign mem_addr       = q[head].addr;
  assign mem_write_data = q[head].data;
  assign mem_pc         = q[head].pc;

  // Queue state; entries cleared on reset so the memory port reads zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      align_err <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      if (push) begin
        q[tail] <= '{opcode: in_opcode, addr: in_addr, data: in_data, pc: in_pc};
        tail    <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (misalign) begin
        align_err <= 1'b1;
      end
    end
  end

  // Scan oldest to youngest so the last match is the youngest store
  always_comb begin
    idx    = '0;
    match  = 1'b0;
    y_op   = '0;
    y_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (q[idx].addr[12:2] == ld_addr[12:2])) begin
        match  = 1'b1;
        y_op   = q[idx].opcode;
        y_data = q[idx].data;
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic fwd_ok;
  assign fwd_ok   = match && (y_op == OP_SW) && (ld_opcode == OP_LW);
  assign ld_hit   = ld_valid && fwd_ok;
  assign ld_data  = ld_hit ? y_data : 32'h0;
  assign ld_stall = ld_valid && match && !fwd_ok;

  logic unused_bits;
  assign unused_bits = ^{ld_addr[31:13], ld_addr[1:0]};
`else
  assign ld_hit   = 1'b0;
  assign ld_data  = 32'h0;
  assign ld_stall = ld_valid && match;

  logic unused_bits;
  assign unused_bits = ^{ld_addr[31:13], ld_addr[1:0], ld_opcode, y_op, y_data};
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected memory writes are queued at issue
// and checked by a negedge monitor; port-level checks are made inline.
module tb_store_buffer;

  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LBU = 6'b100100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_opcode = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic [31:0] in_pc = '0;
  logic        ld_valid = 1'b0;
  logic [5:0]  ld_opcode = '0;
  logic [31:0] ld_addr = '0;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        mem_WR;
  logic [5:0]  mem_opcode;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_pc;
  logic        empty;
  logic        align_err;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_addr(in_addr), .in_data(in_data), .in_pc(in_pc),
    .ld_valid(ld_valid), .ld_opcode(ld_opcode), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
    .mem_WR(mem_WR), .mem_opcode(mem_opcode), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_pc(mem_pc),
    .empty(empty), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit accepted(input logic [5:0] op, input logic [31:0] a);
    return (op == OP_SW && a[1:0] == 2'b00) || (op == OP_SH && !a[0]) || (op == OP_SB);
  endfunction

  // Memory writes sampled mid-cycle, compared against issue order
  always @(negedge clk) begin
    if (reset && mem_WR) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        logic [31:0] mask;
        e = exp_q.pop_front();
        mask = (e.op == OP_SB) ? 32'h0000_00FF : (e.op == OP_SH) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        chk("wr_opcode", 32'(mem_opcode), 32'(e.op));
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_write_data & mask, e.data & mask);
        chk("wr_pc", mem_pc, e.pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one store for one cycle; caller guarantees the queue is not full
  task automatic drive_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] p);
    in_valid  = 1'b1;
    in_opcode = op;
    in_addr   = a;
    in_data   = d;
    in_pc     = p;
    if (accepted(op, a)) exp_q.push_back('{op: op, addr: a, data: d, pc: p});
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    step();
    ld_valid = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (empty === 1'b1) done = 1'b1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_mem_wr", 32'(mem_WR), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_data", mem_write_data, 32'h0);
    chk("rst_mem_pc", mem_pc, 32'h0);
    chk("rst_mem_opcode", 32'(mem_opcode), 32'h0);
    chk("rst_ld_hit", 32'(ld_hit), 32'd0);
    chk("rst_ld_stall", 32'(ld_stall), 32'd0);
    chk("rst_ld_data", ld_data, 32'h0);
    chk("rst_align_err", 32'(align_err), 32'd0);
    step();
    reset = 1'b1;

    // Single sw retires the cycle after the push
    drive_store(OP_SW, 32'h10, 32'hDEADBEEF, 32'h400);
    @(negedge clk);
    chk("t1_mem_wr", 32'(mem_WR), 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_mem_data", mem_write_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_empty", 32'(empty), 32'd1);

    // Fill while a non-matching load holds the port
    step();
    ld_valid  = 1'b1;
    ld_opcode = OP_LW;
    ld_addr   = 32'h100;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'h40 + 32'(i * 4);
      drive_store(OP_SW, a, 32'hA0 + 32'(i), 32'h500 + 32'(i * 4));
    end
    @(negedge clk);
    chk("t2_in_ready_full", 32'(in_ready), 32'd0);
    chk("t2_mem_wr_blocked", 32'(mem_WR), 32'd0);
    chk("t2_no_stall", 32'(ld_stall), 32'd0);
    chk("t2_no_hit", 32'(ld_hit), 32'd0);
    step();
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_mem_wr_run", 32'(mem_WR), 32'd1);
    end
    @(negedge clk);
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_mem_wr_done", 32'(mem_WR), 32'd0);

    // Youngest sw wins on an lw match
    step();
    ld_valid = 1'b1;
    ld_addr  = 32'h100;
    drive_store(OP_SW, 32'h20, 32'h11111111, 32'h600);
    drive_store(OP_SW, 32'h20, 32'h22222222, 32'h604);
    ld_addr   = 32'h20;
    ld_opcode = OP_LW;
    @(negedge clk);
`ifdef STORE_BUFFER_FWD_EN
    chk("t3_ld_hit", 32'(ld_hit), 32'd1);
    chk("t3_ld_data", ld_data, 32'h22222222);
    chk("t3_ld_stall", 32'(ld_stall), 32'd0);
`else
    chk("t3_ld_hit", 32'(ld_hit), 32'd0);
    chk("t3_ld_data", ld_data, 32'h0);
    chk("t3_ld_stall", 32'(ld_stall), 32'd1);
`endif
    step();
    ld_opcode = OP_LH;
    @(negedge clk);
    chk("t3_lh_stall", 32'(ld_stall), 32'd1);
    chk("t3_lh_hit", 32'(ld_hit), 32'd0);
    drain("t3_drain");

    // Sub-word store overlap stalls until the entry retires
    step();
    ld_valid  = 1'b1;
    ld_opcode = OP_LW;
    ld_addr   = 32'h100;
    drive_store(OP_SB, 32'h21, 32'h000000AB, 32'h700);
    ld_addr   = 32'h20;
    ld_opcode = OP_LBU;
    @(negedge clk);
    chk("t4_stall", 32'(ld_stall), 32'd1);
    chk("t4_hit", 32'(ld_hit), 32'd0);
    step();
    ld_valid = 1'b0;
    @(negedge clk);
    chk("t4_pop_wr", 32'(mem_WR), 32'd1);
    step();
    ld_valid = 1'b1;
    @(negedge clk);
    chk("t4_stall_clear", 32'(ld_stall), 32'd0);
    chk("t4_empty", 32'(empty), 32'd1);

    // Alignment drops, non-store ignore, sb always accepted
    step();
    ld_valid = 1'b0;
    drive_store(OP_SW, 32'h32, 32'h33333333, 32'h800);
    @(negedge clk);
    chk("t5_align_err", 32'(align_err), 32'd1);
    chk("t5_sw_empty", 32'(empty), 32'd1);
    step();
    drive_store(OP_SH, 32'h33, 32'h00004444, 32'h804);
    @(negedge clk);
    chk("t5_sh_empty", 32'(empty), 32'd1);
    step();
    drive_store(6'b000000, 32'h34, 32'h55555555, 32'h808);
    @(negedge clk);
    chk("t5_nonstore_empty", 32'(empty), 32'd1);
    step();
    drive_store(OP_SB, 32'h33, 32'h000000CD, 32'h80C);
    @(negedge clk);
    chk("t5_sb_wr", 32'(mem_WR), 32'd1);
    chk("t5_sb_addr", mem_addr, 32'h33);
    @(negedge clk);
    chk("t5_sticky", 32'(align_err), 32'd1);
    chk("t5_sb_empty", 32'(empty), 32'd1);

    // Asynchronous reset discards pending entries
    step();
    ld_valid = 1'b1;
    ld_addr  = 32'h100;
    drive_store(OP_SW, 32'h60, 32'h60606060, 32'h900);
    drive_store(OP_SH, 32'h64, 32'h00006464, 32'h904);
    drive_store(OP_SB, 32'h68, 32'h00000068, 32'h908);
    @(negedge clk);
    chk("t6_pending", 32'(empty), 32'd0);
    #2;
    exp_q.delete();
    ld_valid = 1'b0;
    reset    = 1'b0;
    #1;
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_mem_wr", 32'(mem_WR), 32'd0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
    chk("t6_rst_align", 32'(align_err), 32'd0);
    chk("t6_rst_addr", mem_addr, 32'h0);
    step();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_after_empty", 32'(empty), 32'd1);

    chk("leftover_writes", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write queue between the EX/MEM pipeline register and the data memory. Stores (sw/sb/sh) are accepted into a small FIFO and retired to memory one per cycle whenever the single memory port is not needed by a load. Loads are checked against pending stores and either forwarded, passed to memory, or stalled. This keeps program order while letting stores complete in the background.

## Interface
Parameters:
- DEPTH, 4, number of queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears the queue
- in_valid  in  1  store request from EX/MEM
- in_ready  out  1  queue can accept; equals !full
- in_opcode  in  6  101011 sw, 101000 sb, 101001 sh; other codes are ignored
- in_addr  in  32  byte address
- in_data  in  32  store data (sb uses [7:0], sh uses [15:0])
- in_pc  in  32  PC tag carried with the entry
- ld_valid  in  1  MEM stage load is using the memory port this cycle
- ld_opcode  in  6  load opcode (100011 lw, 100000 lb, 100100 lbu, 100001 lh, 100101 lhu)
- ld_addr  in  32  load byte address
- ld_hit  out  1  load satisfied from the queue; use ld_data instead of memory
- ld_data  out  32  forwarded word
- ld_stall  out  1  load overlaps a pending store that cannot be forwarded; MEM must hold
- mem_WR  out  1  write strobe to memory
- mem_opcode  out  6  head entry opcode
- mem_addr  out  32  head entry address
- mem_write_data  out  32  head entry data
- mem_pc  out  32  head entry PC tag
- empty  out  1  no pending entries
- align_err  out  1  sticky flag: a misaligned store was dropped

## Operation
- Circular FIFO with head pointer, tail pointer and count. Pointer width is log2(DEPTH). Count width is log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push happens when in_valid & in_ready, the opcode is a store, and the address is aligned. Alignment rule: sw requires addr[1:0]==0; sh requires addr[0]==0; sb is always aligned.
- A misaligned store is not pushed and sets align_err. align_err stays set until reset.
- A non-store opcode with in_valid high is ignored and does not affect in_ready.
- mem_WR = !empty & !ld_valid, so loads have priority on the memory port. The mem_* outputs are driven directly from head entry registers. Pop happens at the posedge that ends a cycle with mem_WR=1.
- Simultaneous push and pop: count is unchanged and both pointers advance. Push when full is impossible because in_ready=0.
- Load check is combinational. The load word index ld_addr[12:2] is compared against every valid entry's addr[12:2], including the head entry while it is being written.
  - No match: ld_hit=0, ld_stall=0; the load reads memory.
  - Match where the youngest matching entry is sw and ld_opcode is lw: ld_hit=1, ld_data = that entry's data.
  - Any other match (sub-word store or sub-word load): ld_stall=1, ld_hit=0.
- ld_hit and ld_stall are 0 when ld_valid=0.
- Reset low: count, pointers and align_err go to 0 and all outputs are 0 immediately (asynchronously). Queued entries are discarded, including one in the middle of a write.

## Timing
- Reset values: in_ready=1, empty=1, mem_WR=0, all mem_* outputs 0, ld_hit=0, ld_stall=0, ld_data=0, align_err=0.
- A push at posedge N makes the entry visible to the load check and to the memory port during cycle N+1.
- With no loads, one entry retires per cycle. The memory samples on the negedge inside that cycle.
- Back-to-back stores with ld_valid held low never fill the queue. The queue fills only while loads occupy the port.
- ld_stall deasserts in the cycle after the last overlapping entry pops.

## Configuration
- STORE_BUFFER_FWD_EN defined: lw-from-sw forwarding is enabled as described above.
- STORE_BUFFER_FWD_EN undefined: ld_hit and ld_data are tied to 0, and any word-index match raises ld_stall.

## Test plan
- Reset with DEPTH=4, then push sw addr 0x10 data 0xDEADBEEF with ld_valid=0 -> mem_WR=1 next cycle with mem_addr=0x10 and mem_write_data=0xDEADBEEF; empty=1 one cycle later.
- Hold ld_valid=1 with a non-matching ld_addr 0x100 and push 4 stores -> in_ready=0 after the 4th push. Drop ld_valid -> mem_WR=1 for 4 consecutive cycles in push order.
- Queue sw 0x20=0x11111111 then sw 0x20=0x22222222 while ld_valid=1; load lw 0x20 -> ld_hit=1, ld_data=0x22222222, ld_stall=0. Without the macro -> ld_stall=1.
- Queue sb 0x21=0xAB while ld_valid=1; load lbu 0x20 -> ld_stall=1. Release ld_valid -> entry pops, then ld_stall=0.
- Push sw to 0x32 -> not queued, align_err=1, empty stays 1. Push sh to 0x33 -> also dropped. Push sb to 0x33 -> accepted.
- With 3 entries pending, assert reset low mid-cycle -> empty=1, mem_WR=0 and in_ready=1 immediately; no further memory writes after reset is released.
